// File: rtl/sram_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bist_pkg
//  Purpose  : State encoding, pattern codes and pattern generator shared by
//             the SRAM built-in self-test sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [1:0] c_PAT_ADDR    = 2'd0;
    localparam logic [1:0] c_PAT_NADDR   = 2'd1;
    localparam logic [1:0] c_PAT_CHECKER = 2'd2;
    localparam logic [1:0] c_PAT_ONES    = 2'd3;

    // Widest data word the generator supports; callers truncate to DATA_W.
    localparam int c_PAT_MAX_W = 64;

    function automatic logic [c_PAT_MAX_W-1:0] pattern_data(
        input logic [1:0]             pat,
        input logic [c_PAT_MAX_W-1:0] addr
    );
        logic [c_PAT_MAX_W-1:0] v;
        case (pat)
            c_PAT_ADDR:    v = addr;
            c_PAT_NADDR:   v = ~addr;
            c_PAT_CHECKER: v = addr[0] ? {(c_PAT_MAX_W/2){2'b10}}
                                       : {(c_PAT_MAX_W/2){2'b01}};
            default:       v = '1;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bist_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bist_if
//  Purpose  : Request/response bus between the BIST sequencer and the SRAM
//             controller.
//  Revision : 1.0  initial release
// ============================================================================
interface sram_bist_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              mem;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_f2s;
    logic              ready;
    logic [DATA_W-1:0] data_s2f_r;

    modport master (
        output mem, rw, addr, data_f2s,
        input  ready, data_s2f_r
    );

    modport slave (
        input  mem, rw, addr, data_f2s,
        output ready, data_s2f_r
    );
endinterface
`default_nettype wire

// File: rtl/sram_bist.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bist
//  Purpose  : Writes a selectable pattern to every SRAM word, reads it back,
//             counts miscompares and captures the first failing word.
//  Revision : 1.0  initial release
// ============================================================================
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int LAST_ADDR = 2**18-1,
    parameter int ERR_W     = 16
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic [1:0]        pattern,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_count,
    output logic [ADDR_W-1:0]      fail_addr,
    output logic [DATA_W-1:0]      fail_data,
    output logic [DATA_W-1:0]      fail_exp,
    sram_bist_if.master            bus
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(LAST_ADDR);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [1:0]          r_pat;
    logic [ERR_W-1:0]    r_err;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_data;
    logic [DATA_W-1:0]   r_fail_exp;

    logic                w_accept;
    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic                w_check;
    logic                w_mem;
    logic                w_rw;
    logic                w_busy;
    logic                w_done;
    logic                w_last;
    logic                w_miscompare;
    logic [DATA_W-1:0]   w_exp;

    // Expected word is a pure function of the held counter, so it doubles as
    // write data and stays stable for the whole operation.
    assign w_exp        = DATA_W'(pattern_data(r_pat, c_PAT_MAX_W'(r_cnt)));
    assign w_last       = (r_cnt == c_LAST);
    assign w_miscompare = (bus.data_s2f_r != w_exp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_check      = 1'b0;
        w_mem        = 1'b0;
        w_rw         = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_WR_ISSUE;
                end
            end

            ST_WR_ISSUE: begin
                w_busy = 1'b1;
                w_mem  = bus.ready;
                if (bus.ready) begin
                    w_next_state = ST_WR_WAIT;
                end
            end

            ST_WR_WAIT: begin
                w_busy = 1'b1;
                if (bus.ready) begin
                    if (w_last) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_RD_ISSUE;
                    end else begin
                        w_cnt_inc    = 1'b1;
                        w_next_state = ST_WR_ISSUE;
                    end
                end
            end

            ST_RD_ISSUE: begin
                w_busy = 1'b1;
                w_rw   = 1'b1;
                w_mem  = bus.ready;
                if (bus.ready) begin
                    w_next_state = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                w_busy = 1'b1;
                w_rw   = 1'b1;
                if (bus.ready) begin
                    w_check = 1'b1;
                    if (w_last) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_DONE;
                    end else begin
                        w_cnt_inc    = 1'b1;
                        w_next_state = ST_RD_ISSUE;
                    end
                end
            end

            ST_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_WR_ISSUE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_pat       <= '0;
            r_err       <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_fail_exp  <= '0;
        end else begin
            if (w_accept) begin
                r_pat       <= pattern;
                r_err       <= '0;
                r_fail_addr <= '0;
                r_fail_data <= '0;
                r_fail_exp  <= '0;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end

            // A zero count means no miscompare has been captured yet.
            if (w_check && w_miscompare) begin
                if (r_err != '1) begin
                    r_err <= r_err + ERR_W'(1);
                end
                if (r_err == '0) begin
                    r_fail_addr <= r_cnt;
                    r_fail_data <= bus.data_s2f_r;
                    r_fail_exp  <= w_exp;
                end
            end
        end
    end

    assign bus.mem      = w_mem;
    assign bus.rw       = w_rw;
    assign bus.addr     = r_cnt;
    assign bus.data_f2s = w_exp;

    assign busy      = w_busy;
    assign done      = w_done;
    assign pass      = w_done && (r_err == '0);
    assign err_count = r_err;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign fail_exp  = r_fail_exp;

endmodule
`default_nettype wire
